mux_rr_sel: RTL and testbench

Round-robin request arbiter that drives the `sel` input of the parameterized N-to-1 multiplexer (`mux_param`). It accepts up to 2**bitsel request lines, grants one at a time, and holds the matching select code stable for the downstream mux until a valid/ready transfer completes. It also counts completed transfers. It sits directly upstream of the mux. Its `sel` output connects straight to the mux `sel`, and the mux output is qualified by `out_valid`.

---
 rtl/mux_rr_sel.sv | 130 +++++++++++++
 tb/tb_mux_rr_sel.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mux_rr_sel.sv
// Round-robin arbiter driving the select code of an N-to-1 mux.
// Holds the grant until a valid/ready transfer completes and counts transfers.
module mux_rr_sel #(
    parameter int bitsel = 2,
    parameter int CW     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [(1<<bitsel)-1:0]  req,
    input  logic                    out_ready,
    output logic [bitsel-1:0]       sel,
    output logic [(1<<bitsel)-1:0]  gnt,
    output logic                    out_valid,
    output logic [CW-1:0]           xfer_cnt
);

    localparam int N = 1 << bitsel;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [bitsel-1:0]   ptr_r;
    logic [bitsel-1:0]   ptr_nxt_s;
    logic [bitsel-1:0]   sel_nxt_s;
    logic [N-1:0]        gnt_nxt_s;
    logic                valid_nxt_s;
    logic [CW-1:0]       cnt_nxt_s;
    logic [bitsel-1:0]   pick_idle_s;
    logic [bitsel-1:0]   pick_xfer_s;
    logic [bitsel-1:0]   sel_inc_s;

    // First requester at or after the pointer; index arithmetic wraps modulo N.
    function automatic logic [bitsel-1:0] pick_f(input logic [N-1:0] r,
                                                 input logic [bitsel-1:0] p);
        logic [bitsel-1:0] idx;
        logic              found;
        pick_f = p;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = p + k[bitsel-1:0];
            if (!found && r[idx]) begin
                pick_f = idx;
                found  = 1'b1;
            end
        end
    endfunction

    function automatic logic [N-1:0] onehot_f(input logic [bitsel-1:0] s);
        onehot_f    = {N{1'b0}};
        onehot_f[s] = 1'b1;
    endfunction

    assign sel_inc_s   = sel + bitsel'(1);
    assign pick_idle_s = pick_f(req, ptr_r);
    assign pick_xfer_s = pick_f(req, sel_inc_s);

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        sel_nxt_s   = sel;
        gnt_nxt_s   = gnt;
        valid_nxt_s = out_valid;
        cnt_nxt_s   = xfer_cnt;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    sel_nxt_s   = pick_idle_s;
                    gnt_nxt_s   = onehot_f(pick_idle_s);
                    valid_nxt_s = 1'b1;
                    state_nxt_s = GRANT;
                end else begin
                    gnt_nxt_s   = {N{1'b0}};
                    valid_nxt_s = 1'b0;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    // Requester withdrew: drop the grant, pointer untouched.
                    gnt_nxt_s   = {N{1'b0}};
                    valid_nxt_s = 1'b0;
                    state_nxt_s = IDLE;
                end else if (out_ready) begin
                    cnt_nxt_s = xfer_cnt + CW'(1);
                    ptr_nxt_s = sel_inc_s;
                    if (|req) begin
                        sel_nxt_s   = pick_xfer_s;
                        gnt_nxt_s   = onehot_f(pick_xfer_s);
                        valid_nxt_s = 1'b1;
                    end else begin
                        gnt_nxt_s   = {N{1'b0}};
                        valid_nxt_s = 1'b0;
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: begin
                gnt_nxt_s   = {N{1'b0}};
                valid_nxt_s = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= {bitsel{1'b0}};
            sel       <= {bitsel{1'b0}};
            gnt       <= {N{1'b0}};
            out_valid <= 1'b0;
            xfer_cnt  <= {CW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            sel       <= sel_nxt_s;
            gnt       <= gnt_nxt_s;
            out_valid <= valid_nxt_s;
            xfer_cnt  <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_mux_rr_sel.sv
// Directed bench for mux_rr_sel: a CW=16 instance for the main scenarios and a
// CW=4 instance, driven identically, for counter wrap.
module tb_mux_rr_sel;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic        out_ready;
    logic [1:0]  sel;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [15:0] xfer_cnt;
    logic [1:0]  sel4;
    logic [3:0]  gnt4;
    logic        out_valid4;
    logic [3:0]  xfer_cnt4;

    int checks;
    int errors;

    mux_rr_sel #(.bitsel(2), .CW(16)) dut (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
        .sel(sel), .gnt(gnt), .out_valid(out_valid), .xfer_cnt(xfer_cnt)
    );

    mux_rr_sel #(.bitsel(2), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
        .sel(sel4), .gnt(gnt4), .out_valid(out_valid4), .xfer_cnt(xfer_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_sel, input logic [3:0] e_gnt,
                           input logic e_valid, input logic [15:0] e_cnt);
        chk({tag, ".sel"},   {30'd0, sel},       {30'd0, e_sel});
        chk({tag, ".gnt"},   {28'd0, gnt},       {28'd0, e_gnt});
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e_valid});
        chk({tag, ".cnt"},   {16'd0, xfer_cnt},  {16'd0, e_cnt});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req       = 4'($urandom_range(15, 0));
        out_ready = 1'($urandom_range(1, 0));

        // 1. reset for two cycles with random inputs
        step();
        req = 4'($urandom_range(15, 0));
        step();
        chk_all("reset", 2'd0, 4'b0000, 1'b0, 16'd0);
        chk("reset.cnt4", {28'd0, xfer_cnt4}, 32'd0);
        rst = 1'b0;

        // 2. single requester, continuous transfers
        req       = 4'b0100;
        out_ready = 1'b1;
        step();
        chk_all("single.grant", 2'd2, 4'b0100, 1'b1, 16'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_all("single.xfer", 2'd2, 4'b0100, 1'b1, 16'(i));
        end

        // 3. full rotation
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        step();
        chk_all("rot.first", 2'd0, 4'b0001, 1'b1, 16'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_all("rot.seq", 2'(i % 4), 4'(1 << (i % 4)), 1'b1, 16'(i));
        end

        // 4. backpressure, with a non-granted line toggling mid-stall
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req       = 4'b0011;
        out_ready = 1'b0;
        step();
        chk_all("bp.grant", 2'd0, 4'b0001, 1'b1, 16'd0);
        for (int i = 2; i <= 5; i++) begin
            if (i >= 3) req = 4'b1011;
            step();
            chk_all("bp.stall", 2'd0, 4'b0001, 1'b1, 16'd0);
        end
        out_ready = 1'b1;
        step();
        chk_all("bp.release", 2'd1, 4'b0010, 1'b1, 16'd1);
        out_ready = 1'b0;
        step();
        chk_all("bp.hold", 2'd1, 4'b0010, 1'b1, 16'd1);

        // 5. abort keeps the pointer
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req       = 4'b0010;
        out_ready = 1'b0;
        step();
        chk_all("abort.grant", 2'd1, 4'b0010, 1'b1, 16'd0);
        req = 4'b0000;
        step();
        chk_all("abort.drop", 2'd1, 4'b0000, 1'b0, 16'd0);
        req = 4'b0011;
        step();
        chk_all("abort.regrant", 2'd0, 4'b0001, 1'b1, 16'd0);

        // 6. counter wrap on CW=4, then reset during a stalled grant
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req       = 4'b0001;
        out_ready = 1'b1;
        step();
        chk("wrap.start4", {28'd0, xfer_cnt4}, 32'd0);
        for (int i = 1; i <= 15; i++) step();
        chk("wrap.cnt4_15", {28'd0, xfer_cnt4}, 32'd15);
        step();
        chk("wrap.cnt4_16", {28'd0, xfer_cnt4}, 32'd0);
        chk("wrap.cnt16", {16'd0, xfer_cnt}, 32'd16);
        out_ready = 1'b0;
        step();
        chk_all("midrst.stall", 2'd0, 4'b0001, 1'b1, 16'd16);
        rst = 1'b1;
        step();
        chk_all("midrst", 2'd0, 4'b0000, 1'b0, 16'd0);
        chk("midrst.cnt4", {28'd0, xfer_cnt4}, 32'd0);
        chk("midrst.valid4", {31'd0, out_valid4}, 32'd0);
        chk("midrst.gnt4", {28'd0, gnt4}, 32'd0);
        chk("midrst.sel4", {30'd0, sel4}, 32'd0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
